// File: rtl/sa3x3_feeder_if.sv
// Feeder-side bus of the 3x3 systolic array: job control, weight-row and activation handshakes, array drive.
// stall_cnt exists only when SA_FEEDER_STALL_CNT_EN is defined.
interface sa3x3_feeder_if #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 5
);
  logic              start;
  logic [CNT_W-1:0]  num_vec;
  logic              busy, done, clear;
  logic              w_row_valid, w_row_ready;
  logic [DATA_W-1:0] w_row_c1, w_row_c2, w_row_c3;
  logic              weight_load;
  logic [DATA_W-1:0] w_out1, w_out2, w_out3;
  logic              act_valid, act_ready;
  logic [DATA_W-1:0] act_v1, act_v2, act_v3;
  logic [DATA_W-1:0] act_out1, act_out2, act_out3;
  logic              act_tag1, act_tag2, act_tag3;
`ifdef SA_FEEDER_STALL_CNT_EN
  logic [15:0]       stall_cnt;
`endif

  modport master (
    output start, num_vec, w_row_valid, w_row_c1, w_row_c2, w_row_c3,
           act_valid, act_v1, act_v2, act_v3,
    input  busy, done, clear, w_row_ready, weight_load, w_out1, w_out2, w_out3,
           act_ready, act_out1, act_out2, act_out3, act_tag1, act_tag2, act_tag3
`ifdef SA_FEEDER_STALL_CNT_EN
    , input stall_cnt
`endif
  );

  modport slave (
    input  start, num_vec, w_row_valid, w_row_c1, w_row_c2, w_row_c3,
           act_valid, act_v1, act_v2, act_v3,
    output busy, done, clear, w_row_ready, weight_load, w_out1, w_out2, w_out3,
           act_ready, act_out1, act_out2, act_out3, act_tag1, act_tag2, act_tag3
`ifdef SA_FEEDER_STALL_CNT_EN
    , output stall_cnt
`endif
  );
endinterface

// File: rtl/sa3x3_feeder.sv
// Weight preload and diagonally skewed activation feeder for the 3x3 weight-stationary array.
// Optional stall counter enabled by SA_FEEDER_STALL_CNT_EN.
module sa3x3_feeder #(
  parameter int DATA_W    = 8,
  parameter int CNT_W     = 5,
  parameter int DRAIN_CYC = 6
) (
  input logic           clk,
  input logic           rst,
  sa3x3_feeder_if.slave bus
);
  typedef enum logic [2:0] {IDLE, LOAD_W, SHIFT_W, STREAM, DRAIN, DONE} state_e;
  typedef logic [2:0][DATA_W-1:0] row_t;  // [2]=col1 .. [0]=col3
  localparam int PH_W = $clog2(DRAIN_CYC + 3);

  state_e            state_q, state_d;
  logic [PH_W-1:0]   ph_q, ph_d;
  logic [CNT_W-1:0]  rem_q, rem_d;
  row_t [2:0]        buf_q, buf_d;
  row_t              w_out_q, w_out_d;
  logic              busy_q, busy_d, done_q, done_d, clear_q, clear_d;
  logic              w_row_ready_q, w_row_ready_d, weight_load_q, weight_load_d;
  logic              act_ready_q, act_ready_d;
  logic [DATA_W-1:0] act1_q, act1_d;
  logic [1:0][DATA_W-1:0] r2_q, r2_d;
  logic [2:0][DATA_W-1:0] r3_q, r3_d;
  logic              tag1_q, tag1_d;
  logic [1:0]        t2_q, t2_d;
  logic [2:0]        t3_q, t3_d;
  logic              w_acc, a_acc;
  logic [1:0]        sidx;

  assign w_acc = bus.w_row_valid & w_row_ready_q;
  assign a_acc = bus.act_valid & act_ready_q;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    ph_d    = ph_q;
    rem_d   = rem_q;
    buf_d   = buf_q;
    case (state_q)
      IDLE: if (bus.start) begin
        rem_d   = bus.num_vec;
        ph_d    = '0;
        state_d = LOAD_W;
      end
      LOAD_W: if (w_acc) begin
        buf_d[ph_q[1:0]] = {bus.w_row_c1, bus.w_row_c2, bus.w_row_c3};
        if (ph_q == PH_W'(2)) begin
          ph_d    = '0;
          state_d = SHIFT_W;
        end else ph_d = ph_q + 1'b1;
      end
      SHIFT_W: if (ph_q == PH_W'(2)) begin
        ph_d    = '0;
        state_d = (rem_q == '0) ? DRAIN : STREAM;
      end else ph_d = ph_q + 1'b1;
      STREAM: if (a_acc) begin
        rem_d = rem_q - 1'b1;
        if (rem_q == CNT_W'(1)) state_d = DRAIN;
      end
      DRAIN: if (ph_q == PH_W'(DRAIN_CYC - 1)) begin
        ph_d    = '0;
        state_d = DONE;
      end else ph_d = ph_q + 1'b1;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from the next state so each flop lines up with state_q.
  always_comb begin
    busy_d        = (state_d != IDLE);
    done_d        = (state_d == DONE);
    clear_d       = (state_q == IDLE) && (state_d == LOAD_W);
    w_row_ready_d = (state_d == LOAD_W);
    weight_load_d = (state_d == SHIFT_W);
    act_ready_d   = (state_d == STREAM) && (rem_d != '0);
    sidx          = 2'd2 - ph_d[1:0];
    w_out_d       = '0;
    // buf_d already holds the third row on SHIFT_W entry, so it is the bypass too
    if (state_d == SHIFT_W) w_out_d = buf_d[sidx];
    act1_d = a_acc ? bus.act_v1 : '0;
    tag1_d = a_acc;
    r2_d   = {r2_q[0], (a_acc ? bus.act_v2 : DATA_W'(0))};
    t2_d   = {t2_q[0], a_acc};
    r3_d   = {r3_q[1:0], (a_acc ? bus.act_v3 : DATA_W'(0))};
    t3_d   = {t3_q[1:0], a_acc};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ph_q <= '0; rem_q <= '0; buf_q <= '0; w_out_q <= '0;
      busy_q <= 1'b0; done_q <= 1'b0; clear_q <= 1'b0;
      w_row_ready_q <= 1'b0; weight_load_q <= 1'b0; act_ready_q <= 1'b0;
      act1_q <= '0; r2_q <= '0; r3_q <= '0;
      tag1_q <= 1'b0; t2_q <= '0; t3_q <= '0;
    end else begin
      ph_q <= ph_d; rem_q <= rem_d; buf_q <= buf_d; w_out_q <= w_out_d;
      busy_q <= busy_d; done_q <= done_d; clear_q <= clear_d;
      w_row_ready_q <= w_row_ready_d; weight_load_q <= weight_load_d; act_ready_q <= act_ready_d;
      act1_q <= act1_d; r2_q <= r2_d; r3_q <= r3_d;
      tag1_q <= tag1_d; t2_q <= t2_d; t3_q <= t3_d;
    end
  end

`ifdef SA_FEEDER_STALL_CNT_EN
  logic [15:0] stall_q, stall_d;
  always_comb begin
    stall_d = stall_q;
    if (state_q == IDLE && bus.start) stall_d = '0;
    else if (state_q == STREAM && act_ready_q && !bus.act_valid && stall_q != 16'hFFFF)
      stall_d = stall_q + 16'd1;
  end
  always_ff @(posedge clk) begin
    if (rst) stall_q <= '0;
    else     stall_q <= stall_d;
  end
  assign bus.stall_cnt = stall_q;
`endif

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.clear       = clear_q;
  assign bus.w_row_ready = w_row_ready_q;
  assign bus.weight_load = weight_load_q;
  assign bus.w_out1      = w_out_q[2];
  assign bus.w_out2      = w_out_q[1];
  assign bus.w_out3      = w_out_q[0];
  assign bus.act_ready   = act_ready_q;
  assign bus.act_out1    = act1_q;
  assign bus.act_out2    = r2_q[1];
  assign bus.act_out3    = r3_q[2];
  assign bus.act_tag1    = tag1_q;
  assign bus.act_tag2    = t2_q[1];
  assign bus.act_tag3    = t3_q[2];
endmodule

// File: tb/tb_sa3x3_feeder.sv
// Scoreboard bench for sa3x3_feeder: stimulus tasks queue expected outputs with their cycle,
// a negedge monitor pops and compares whenever the DUT presents weights, activations, clear or done.
module tb_sa3x3_feeder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sa3x3_feeder_if #(.DATA_W(8), .CNT_W(5)) bus ();
  sa3x3_feeder #(.DATA_W(8), .CNT_W(5), .DRAIN_CYC(6)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {int cyc; logic [23:0] val;} exp_t;
  exp_t q1[$], q2[$], q3[$], qw[$];
  int qd[$], qc[$];
  int cyc = 0, total = 0, bad = 0, cur_rem = 0, nrow = 0;
  bit mon_en = 0;
  logic [23:0] wrow[3];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h cyc=%0d", name, got, want, cyc);
    end
  endtask

  task automatic chk_act(input int r, input logic tag, input logic [7:0] val);
    exp_t e;
    bit have = 0;
    total++;
    if (tag) begin
      case (r)
        1: if (q1.size() != 0) begin e = q1.pop_front(); have = 1; end
        2: if (q2.size() != 0) begin e = q2.pop_front(); have = 1; end
        default: if (q3.size() != 0) begin e = q3.pop_front(); have = 1; end
      endcase
      if (!have) begin
        bad++; $display("FAIL act%0d unexpected got=%0d want=none cyc=%0d", r, val, cyc);
      end else if (e.cyc != cyc || e.val[7:0] != val) begin
        bad++; $display("FAIL act%0d got=%0d@%0d want=%0d@%0d", r, val, cyc, e.val[7:0], e.cyc);
      end
    end else if (val != 8'd0) begin
      bad++; $display("FAIL act%0d bubble got=%0d want=0 cyc=%0d", r, val, cyc);
    end
  endtask

  task automatic chk_pulse(input string name, input logic p, input bit is_done);
    int d;
    if (!p) return;
    total++;
    if (is_done ? (qd.size() == 0) : (qc.size() == 0)) begin
      bad++; $display("FAIL %s unexpected got=cyc%0d want=none", name, cyc);
    end else begin
      d = is_done ? qd.pop_front() : qc.pop_front();
      if (d != cyc) begin bad++; $display("FAIL %s got=cyc%0d want=cyc%0d", name, cyc, d); end
    end
  endtask

  always @(negedge clk) if (mon_en) begin
    exp_t e;
    logic [23:0] w;
    chk_act(1, bus.act_tag1, bus.act_out1);
    chk_act(2, bus.act_tag2, bus.act_out2);
    chk_act(3, bus.act_tag3, bus.act_out3);
    chk_pulse("done", bus.done, 1'b1);
    chk_pulse("clear", bus.clear, 1'b0);
    w = {bus.w_out1, bus.w_out2, bus.w_out3};
    total++;
    if (bus.weight_load) begin
      if (qw.size() == 0) begin
        bad++; $display("FAIL wload unexpected got=%06h want=none cyc=%0d", w, cyc);
      end else begin
        e = qw.pop_front();
        if (e.cyc != cyc || e.val != w) begin
          bad++; $display("FAIL wload got=%06h@%0d want=%06h@%0d", w, cyc, e.val, e.cyc);
        end
      end
    end else if (w != 24'd0) begin
      bad++; $display("FAIL w_out idle got=%06h want=0 cyc=%0d", w, cyc);
    end
  end

  task automatic start_job(input int n);
    bus.start = 1'b1; bus.num_vec = 5'(n);
    if (mon_en) qc.push_back(cyc + 1);
    cur_rem = n; nrow = 0;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic send_row(input logic [23:0] r);
    bit ok = 0;
    int k;
    bus.w_row_valid = 1'b1;
    {bus.w_row_c1, bus.w_row_c2, bus.w_row_c3} = r;
    for (int i = 0; i < 100 && !ok; i++) begin
      if (bus.w_row_ready) begin
        ok = 1; k = cyc + 1; wrow[nrow] = r; nrow++;
        if (nrow == 3 && mon_en) begin
          qw.push_back('{k, wrow[2]}); qw.push_back('{k + 1, wrow[1]}); qw.push_back('{k + 2, wrow[0]});
          if (cur_rem == 0) qd.push_back(k + 9);
        end
      end
      @(negedge clk);
    end
    bus.w_row_valid = 1'b0;
    if (!ok) begin total++; bad++; $display("FAIL w_row timeout got=none want=accept"); end
  endtask

  task automatic send_act(input logic [23:0] v);
    bit ok = 0;
    int m;
    bus.act_valid = 1'b1;
    {bus.act_v1, bus.act_v2, bus.act_v3} = v;
    for (int i = 0; i < 100 && !ok; i++) begin
      if (bus.act_ready) begin
        ok = 1; m = cyc + 1; cur_rem--;
        if (mon_en) begin
          q1.push_back('{m, {16'd0, v[23:16]}});
          q2.push_back('{m + 1, {16'd0, v[15:8]}});
          q3.push_back('{m + 2, {16'd0, v[7:0]}});
          if (cur_rem == 0) qd.push_back(m + 6);
        end
      end
      @(negedge clk);
    end
    bus.act_valid = 1'b0;
    if (!ok) begin total++; bad++; $display("FAIL act timeout got=none want=accept"); end
  endtask

  task automatic load3(input logic [23:0] a, input logic [23:0] b, input logic [23:0] c);
    send_row(a); send_row(b); send_row(c);
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int i = 0; i < 300 && !ok; i++) begin
      if (!bus.busy) ok = 1;
      else @(negedge clk);
    end
    if (!ok) begin total++; bad++; $display("FAIL idle timeout got=busy want=idle"); end
    repeat (2) @(negedge clk);
  endtask

  function automatic logic [63:0] all_outs();
    return {7'd0, bus.busy, bus.done, bus.clear, bus.w_row_ready, bus.weight_load, bus.act_ready,
            bus.w_out1, bus.w_out2, bus.w_out3, bus.act_out1, bus.act_out2, bus.act_out3,
            bus.act_tag1, bus.act_tag2, bus.act_tag3};
  endfunction

  initial begin
    bit seen_done;
    bus.start = 0; bus.num_vec = '0; bus.w_row_valid = 0; bus.act_valid = 0;
    bus.w_row_c1 = 0; bus.w_row_c2 = 0; bus.w_row_c3 = 0;
    bus.act_v1 = 0; bus.act_v2 = 0; bus.act_v3 = 0;
    repeat (2) @(negedge clk);
    check("reset_outs", all_outs(), 64'd0);
    rst = 1'b0; mon_en = 1;

    // weight preload, empty job
    start_job(0);
    load3(24'h010203, 24'h040506, 24'h070809);
    wait_idle();

    // skew with back-to-back vectors
    start_job(2);
    load3(24'h111213, 24'h212223, 24'h313233);
    send_act(24'h0A141E); send_act(24'h0B151F);
    wait_idle();

    // two-cycle bubble
    start_job(2);
    load3(24'h050607, 24'h08090A, 24'h0B0C0D);
    send_act(24'h2A3A4A);
    repeat (2) @(negedge clk);
    send_act(24'h2B3B4B);
    wait_idle();
`ifdef SA_FEEDER_STALL_CNT_EN
    check("stall_cnt", 64'(bus.stall_cnt), 64'd2);
`endif

    // weight backpressure, then a late row that must be refused
    start_job(1);
    send_row(24'hA1A2A3); @(negedge clk);
    send_row(24'hB1B2B3); @(negedge clk);
    send_row(24'hC1C2C3);
    bus.w_row_valid = 1'b1; {bus.w_row_c1, bus.w_row_c2, bus.w_row_c3} = 24'h636363;
    for (int i = 0; i < 3; i++) begin
      check("late_row_ready", 64'(bus.w_row_ready), 64'd0);
      @(negedge clk);
    end
    bus.w_row_valid = 1'b0;
    send_act(24'hFF8001);
    wait_idle();

    // reset mid-stream, monitor paused while the job is abandoned
    mon_en = 0;
    start_job(2);
    load3(24'h101010, 24'h202020, 24'h303030);
    send_act(24'h445566);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_outs", all_outs(), 64'd0);
    seen_done = 0;
    repeat (15) begin @(negedge clk); if (bus.done) seen_done = 1; end
    check("midrst_no_done", 64'(seen_done), 64'd0);
    mon_en = 1;
    start_job(1);
    load3(24'h0F0E0D, 24'h0C0B0A, 24'h090807);
    send_act(24'h778899);
    wait_idle();

    // second start while busy is ignored
    start_job(3);
    load3(24'h121314, 24'h151617, 24'h18191A);
    send_act(24'h010101);
    bus.start = 1'b1; bus.num_vec = 5'd7;
    @(negedge clk);
    bus.start = 1'b0;
    send_act(24'h020202); send_act(24'h030303);
    wait_idle();
    repeat (5) @(negedge clk);
    check("busy_after_job", 64'(bus.busy), 64'd0);

    check("q_act1_empty", 64'(q1.size()), 64'd0);
    check("q_act2_empty", 64'(q2.size()), 64'd0);
    check("q_act3_empty", 64'(q3.size()), 64'd0);
    check("q_w_empty", 64'(qw.size()), 64'd0);
    check("q_done_empty", 64'(qd.size()), 64'd0);
    check("q_clear_empty", 64'(qc.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sa3x3_feeder.md
Name: sa3x3_feeder

Overview:
- Upstream stage of the 3x3 weight-stationary systolic array. It accepts a 3x3 weight tile and a stream of 3-element activation vectors.
- Weights: preloaded into the array by shifting them down the columns under weight_load.
- Activations: driven into the three array rows with a diagonal skew (row r delayed r-1 cycles), with zero bubbles where no data is available.
- Per-row tag bits travel with the skewed activations so the downstream collector can identify valid results.

Parameters:
- DATA_W, 8, width of weight and activation elements.
- CNT_W, 5, width of the vector count; max job length is 2^CNT_W-1.
- DRAIN_CYC, 6, zero-injection cycles after the last vector, needed to flush the array.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  job start pulse; sampled in IDLE only.
- num_vec  in  CNT_W  number of activation vectors; sampled with start.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at job end.
- clear  out  1  to array clear; one-cycle pulse.
- w_row_valid  in  1  weight row offered.
- w_row_ready  out  1  feeder accepts a weight row.
- w_row_c1, w_row_c2, w_row_c3  in  DATA_W each  weight row elements for columns 1..3.
- weight_load  out  1  to array weight_load.
- w_out1, w_out2, w_out3  out  DATA_W each  to array w_in1..3.
- act_valid  in  1  activation vector offered.
- act_ready  out  1  feeder accepts a vector.
- act_v1, act_v2, act_v3  in  DATA_W each  vector elements for rows 1..3.
- act_out1, act_out2, act_out3  out  DATA_W each  to array act_in1..3 (skewed).
- act_tag1, act_tag2, act_tag3  out  1 each  high when act_outN carries real data, not a bubble.

Behaviour:
- Clock and reset:
  - Single clock clk; reset rst is synchronous and active-high.
  - All outputs are registered.
  - Reset values: busy=0, done=0, clear=0, w_row_ready=0, weight_load=0, act_ready=0. All w_out*, act_out* and act_tag* are 0. State is IDLE. The weight buffer, skew registers and counters are all cleared.
- States: IDLE, LOAD_W, SHIFT_W, STREAM, DRAIN, DONE.
- IDLE:
  - start=1 latches num_vec and moves to LOAD_W.
  - clear=1 during the first LOAD_W cycle only.
- LOAD_W:
  - w_row_ready=1. A row is accepted on a cycle with w_row_valid and w_row_ready both high.
  - Rows arrive in array-row order 1,2,3 and are stored in buffer slots 0..2.
  - The third accept moves to SHIFT_W.
- SHIFT_W:
  - Exactly 3 cycles with weight_load=1.
  - w_out* drives the buffered rows in order 3, 2, 1, so that after the third cycle PE row r holds weight row r.
  - In the cycle after SHIFT_W: weight_load=0 and w_out*=0.
  - Next state is STREAM, or DRAIN if num_vec==0.
- STREAM:
  - act_ready=1 while the remaining count is >0. A vector is accepted on a cycle with act_valid and act_ready both high; each accept decrements the count.
  - Skew: the element for row 1 appears on act_out1 one cycle after accept. Row 2 appears one cycle later than row 1, row 3 two cycles later. The matching act_tagN bits follow the same delays.
  - Cycles without an accept inject 0 with tag 0 on the row-1 input of the skew chain.
  - After the last accept, act_ready drops in the next cycle and the state moves to DRAIN.
- DRAIN:
  - DRAIN_CYC cycles of zero/tag-0 injection. Skew registers keep shifting, so pending rows 2 and 3 still emerge.
  - Then moves to DONE.
- DONE: done=1 for one cycle, then IDLE (busy=0 in that IDLE cycle).
- Boundary conditions:
  - start while busy is ignored.
  - w_row_valid and act_valid outside their states are ignored and never accepted.
  - rst asserted mid-job: next cycle is IDLE with reset values, and no done pulse occurs.
  - num_vec=0 gives a job of clear, weight load, drain and done with no activation accept.
  - Activation values pass through unchanged; the feeder does no arithmetic. The vector counter does not wrap because num_vec is bounded by CNT_W.

Optional Feature:
- Macro: SA_FEEDER_STALL_CNT_EN.
- Defined:
  - Adds output stall_cnt (16 bits), cleared on start.
  - Increments on each STREAM cycle with act_ready=1 and act_valid=0; saturates at 0xFFFF.
  - Holds its value after done until the next start.
- Undefined: the port and counter are absent, and behaviour is otherwise identical.

Test Plan:
1. Weight preload:
   - Stimulus: start with num_vec=0; rows (1,2,3),(4,5,6),(7,8,9) offered back-to-back.
   - Response: clear pulses once. weight_load is high for 3 cycles with w_out = (7,8,9),(4,5,6),(1,2,3). done follows DRAIN_CYC+1 cycles after SHIFT_W ends.
2. Skew:
   - Stimulus: num_vec=2, vectors (10,20,30),(11,21,31) accepted on consecutive cycles.
   - Response: act_out1 = 10,11 on cycles t+1,t+2. act_out2 = 20,21 on t+2,t+3. act_out3 = 30,31 on t+3,t+4. Tags are high exactly on those cycles.
3. Bubble:
   - Stimulus: num_vec=2 with a 2-cycle act_valid gap between vectors.
   - Response: each row shows two 0/tag-0 cycles between the values. With SA_FEEDER_STALL_CNT_EN defined, stall_cnt=2.
4. Backpressure on weights:
   - Stimulus: w_row_valid toggles 1,0,1,0,1.
   - Response: exactly 3 rows are stored, in arrival order. Weights received after the third row are not accepted.
5. Reset mid-STREAM:
   - Stimulus: rst is asserted for 1 cycle after the first vector is accepted.
   - Response: the next cycle shows all outputs zero and busy=0, with no done pulse. A new start then runs a full job correctly.
6. start while busy:
   - Stimulus: a second start pulse during STREAM.
   - Response: no effect; exactly one done pulse occurs.
